// File: rtl/ibex_efpga_seq_if.sv
// Fabric-side bus between the EX-stage eFPGA sequencer and the custom-instruction fabric.
// The sequencer takes the master modport, the fabric (or its model) takes the slave modport.
interface ibex_efpga_seq_if;
  logic        fab_op_valid_o;
  logic [1:0]  fab_optype_o;
  logic [31:0] fab_operand_a_o;
  logic [31:0] fab_operand_b_o;
  logic [31:0] fab_result_a_i;
  logic [31:0] fab_result_b_i;
  logic [31:0] fab_result_c_i;
  logic        fab_done_i;
  logic        fab_abort_o;

  modport master (
    output fab_op_valid_o,
    output fab_optype_o,
    output fab_operand_a_o,
    output fab_operand_b_o,
    input  fab_result_a_i,
    input  fab_result_b_i,
    input  fab_result_c_i,
    input  fab_done_i,
    output fab_abort_o
  );

  modport slave (
    input  fab_op_valid_o,
    input  fab_optype_o,
    input  fab_operand_a_o,
    input  fab_operand_b_o,
    output fab_result_a_i,
    output fab_result_b_i,
    output fab_result_c_i,
    output fab_done_i,
    input  fab_abort_o
  );
endinterface

// File: rtl/ibex_efpga_seq.sv
// Sequencer between the EX stage and the eFPGA fabric: latches an op, launches it, times
// completion (fixed latency or done handshake with timeout), then holds the result for EX.
module ibex_efpga_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   flush_i,
  input  logic [1:0]             optype_i,
  input  logic [31:0]            operand_a_i,
  input  logic [31:0]            operand_b_i,
  input  logic [3:0]             delay_i,
  ibex_efpga_seq_if.master       fab,
  output logic                   ready_o,
  output logic [31:0]            result_o,
  output logic                   busy_o,
  output logic                   timeout_o,
  output logic                   err_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    optype_q;
  logic [31:0]   operand_a_q;
  logic [31:0]   operand_b_q;
  logic [3:0]    delay_q;
  logic [3:0]    dcnt_q;
  logic [TW-1:0] tcnt_q;
  logic [31:0]   result_q;
  logic          timeout_q;
  logic          err_q;

  logic          start;
  logic          illegal;
  logic          hs_mode;
  logic          capture;
  logic          expire;
  logic [31:0]   result_sel;

  // Event decode; flush masks every transition-causing event.
  always_comb begin
    start   = (state_q == IDLE) && en_i && !flush_i;
    illegal = start && (optype_i == 2'd3);
    hs_mode = (delay_q == 4'hF);
    capture = 1'b0;
    expire  = 1'b0;
    if (!flush_i) begin
      case (state_q)
        LAUNCH: capture = (delay_q == 4'd0);
        WAIT: begin
          if (hs_mode) begin
            capture = fab.fab_done_i;
            expire  = !fab.fab_done_i && (tcnt_q == TCNT_LAST);
          end else begin
            capture = (dcnt_q == 4'd1);
          end
        end
        default: ;
      endcase
    end
    case (optype_q)
      2'd0:    result_sel = fab.fab_result_a_i;
      2'd1:    result_sel = fab.fab_result_b_i;
      default: result_sel = fab.fab_result_c_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (en_i) state_d = illegal ? DONE : LAUNCH;
        LAUNCH:  state_d = (delay_q == 4'd0) ? DONE : WAIT;
        WAIT:    if (capture || expire) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    fab.fab_op_valid_o  = (state_q == LAUNCH) && !flush_i;
    fab.fab_abort_o     = flush_i && ((state_q == LAUNCH) || (state_q == WAIT));
    fab.fab_optype_o    = optype_q;
    fab.fab_operand_a_o = operand_a_q;
    fab.fab_operand_b_o = operand_b_q;
    ready_o             = (state_q == IDLE) ? !en_i : (state_q == DONE);
    busy_o              = (state_q != IDLE);
    result_o            = result_q;
    timeout_o           = timeout_q;
    err_o               = err_q;
  end

  // Status flags are set on the edge into DONE and drop on the edge back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      optype_q    <= 2'd0;
      operand_a_q <= 32'd0;
      operand_b_q <= 32'd0;
      delay_q     <= 4'd0;
      dcnt_q      <= 4'd0;
      tcnt_q      <= '0;
      result_q    <= 32'd0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      if (start) begin
        optype_q    <= optype_i;
        operand_a_q <= operand_a_i;
        operand_b_q <= operand_b_i;
        delay_q     <= delay_i;
      end
      if (illegal) begin
        result_q <= 32'd0;
        err_q    <= 1'b1;
      end
      if (state_q == LAUNCH) begin
        dcnt_q <= delay_q;
        tcnt_q <= '0;
      end
      if (state_q == WAIT) begin
        dcnt_q <= dcnt_q - 4'd1;
        tcnt_q <= tcnt_q + 1'b1;
      end
      if (capture) result_q <= result_sel;
      if (expire) begin
        result_q  <= 32'd0;
        timeout_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ibex_efpga_seq.sv
// Directed self-checking bench for ibex_efpga_seq: fixed latency, handshake, timeout,
// flush, illegal op, back-to-back and async reset, with hand-computed expectations.
module tb_ibex_efpga_seq;

  logic        clk;
  logic        rst_n;
  logic        en_i;
  logic        flush_i;
  logic [1:0]  optype_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic [3:0]  delay_i;
  logic        ready_o;
  logic [31:0] result_o;
  logic        busy_o;
  logic        timeout_o;
  logic        err_o;

  int n_assert;
  int n_fail;

  ibex_efpga_seq_if fab_if ();

  ibex_efpga_seq #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en_i),
    .flush_i     (flush_i),
    .optype_i    (optype_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .delay_i     (delay_i),
    .fab         (fab_if),
    .ready_o     (ready_o),
    .result_o    (result_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic en, input logic [1:0] optype,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] delay);
    en_i        = en;
    optype_i    = optype;
    operand_a_i = a;
    operand_b_i = b;
    delay_i     = delay;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Inputs change just after the rising edge; checks happen on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
    next_cycle();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    flush_i  = 1'b0;
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
    fab_if.fab_result_a_i = 32'd0;
    fab_if.fab_result_b_i = 32'd0;
    fab_if.fab_result_c_i = 32'd0;
    fab_if.fab_done_i     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    sample();
    checkOutput("rst_ready",   ready_o,               1);
    checkOutput("rst_busy",    busy_o,                0);
    checkOutput("rst_result",  result_o,              0);
    checkOutput("rst_valid",   fab_if.fab_op_valid_o, 0);
    checkOutput("rst_abort",   fab_if.fab_abort_o,    0);
    checkOutput("rst_timeout", timeout_o,             0);
    checkOutput("rst_err",     err_o,                 0);
    checkOutput("rst_opa",     fab_if.fab_operand_a_o, 0);
    next_cycle();

    $display("[TB] fixed latency, delay 3");
    fab_if.fab_result_a_i = 32'h12345678;
    fab_if.fab_result_b_i = 32'h22222222;
    fab_if.fab_result_c_i = 32'h33333333;
    applyStimulus(1'b1, 2'd0, 32'h12345678, 32'h0BADF00D, 4'd3);
    sample();
    checkOutput("t1_c0_ready", ready_o, 0);
    checkOutput("t1_c0_valid", fab_if.fab_op_valid_o, 0);
    next_cycle();
    operand_a_i = 32'hFFFFFFFF;
    sample();
    checkOutput("t1_c1_valid",  fab_if.fab_op_valid_o, 1);
    checkOutput("t1_c1_ready",  ready_o, 0);
    checkOutput("t1_c1_opa",    fab_if.fab_operand_a_o, 32'h12345678);
    checkOutput("t1_c1_opb",    fab_if.fab_operand_b_o, 32'h0BADF00D);
    checkOutput("t1_c1_optype", fab_if.fab_optype_o, 0);
    next_cycle();
    fab_if.fab_done_i = 1'b1;
    sample();
    checkOutput("t1_c2_valid", fab_if.fab_op_valid_o, 0);
    checkOutput("t1_c2_ready", ready_o, 0);
    next_cycle();
    fab_if.fab_done_i = 1'b0;
    for (int c = 3; c <= 4; c++) begin
      sample();
      checkOutput("t1_wait_ready", ready_o, 0);
      checkOutput("t1_wait_busy",  busy_o,  1);
      next_cycle();
    end
    sample();
    checkOutput("t1_c5_ready",   ready_o,  1);
    checkOutput("t1_c5_result",  result_o, 32'h12345678);
    checkOutput("t1_c5_timeout", timeout_o, 0);
    checkOutput("t1_c5_err",     err_o,    0);
    next_cycle();
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
    fab_if.fab_result_a_i = 32'd0;
    sample();
    checkOutput("t1_c6_busy",   busy_o,   0);
    checkOutput("t1_c6_ready",  ready_o,  1);
    checkOutput("t1_c6_result", result_o, 32'h12345678);
    next_cycle();

    $display("[TB] zero delay, result C");
    fab_if.fab_result_c_i = 32'hDEADBEEF;
    applyStimulus(1'b1, 2'd2, 32'h1, 32'h2, 4'd0);
    sample();
    checkOutput("t2_c0_ready", ready_o, 0);
    next_cycle();
    sample();
    checkOutput("t2_c1_valid", fab_if.fab_op_valid_o, 1);
    checkOutput("t2_c1_ready", ready_o, 0);
    next_cycle();
    sample();
    checkOutput("t2_c2_ready",  ready_o,  1);
    checkOutput("t2_c2_result", result_o, 32'hDEADBEEF);
    next_cycle();
    idle_cycle();

    $display("[TB] handshake, done at cycle 6");
    fab_if.fab_result_b_i = 32'hA5A5A5A5;
    applyStimulus(1'b1, 2'd1, 32'h0, 32'h5A5A0000, 4'hF);
    next_cycle();
    sample();
    checkOutput("t3_c1_valid", fab_if.fab_op_valid_o, 1);
    next_cycle();
    for (int c = 2; c <= 5; c++) begin
      sample();
      checkOutput("t3_wait_ready", ready_o, 0);
      checkOutput("t3_wait_opb",   fab_if.fab_operand_b_o, 32'h5A5A0000);
      next_cycle();
    end
    fab_if.fab_done_i = 1'b1;
    sample();
    checkOutput("t3_c6_ready", ready_o, 0);
    next_cycle();
    fab_if.fab_done_i = 1'b0;
    sample();
    checkOutput("t3_c7_ready",   ready_o,   1);
    checkOutput("t3_c7_result",  result_o,  32'hA5A5A5A5);
    checkOutput("t3_c7_timeout", timeout_o, 0);
    next_cycle();
    idle_cycle();

    $display("[TB] handshake timeout, TIMEOUT_CYCLES=8");
    fab_if.fab_result_a_i = 32'h77777777;
    applyStimulus(1'b1, 2'd0, 32'h0, 32'h0, 4'hF);
    next_cycle();
    next_cycle();
    for (int c = 2; c <= 9; c++) begin
      sample();
      checkOutput("t4_wait_ready",   ready_o,   0);
      checkOutput("t4_wait_timeout", timeout_o, 0);
      next_cycle();
    end
    sample();
    checkOutput("t4_c10_ready",   ready_o,   1);
    checkOutput("t4_c10_result",  result_o,  32'd0);
    checkOutput("t4_c10_timeout", timeout_o, 1);
    next_cycle();
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
    sample();
    checkOutput("t4_c11_busy",    busy_o,    0);
    checkOutput("t4_c11_timeout", timeout_o, 0);
    next_cycle();

    $display("[TB] flush in WAIT, then a normal op");
    fab_if.fab_result_a_i = 32'h11111111;
    applyStimulus(1'b1, 2'd0, 32'h11111111, 32'h0, 4'd5);
    next_cycle();
    next_cycle();
    next_cycle();
    flush_i = 1'b1;
    en_i    = 1'b0;
    sample();
    checkOutput("t5_c3_abort", fab_if.fab_abort_o, 1);
    checkOutput("t5_c3_ready", ready_o, 0);
    next_cycle();
    flush_i = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      sample();
      checkOutput("t5_post_busy",   busy_o,   0);
      checkOutput("t5_post_abort",  fab_if.fab_abort_o, 0);
      checkOutput("t5_post_result", result_o, 32'd0);
      next_cycle();
    end
    fab_if.fab_result_c_i = 32'hCAFEF00D;
    applyStimulus(1'b1, 2'd2, 32'h0, 32'h0, 4'd1);
    next_cycle();
    sample();
    checkOutput("t5_new_c1_valid", fab_if.fab_op_valid_o, 1);
    next_cycle();
    sample();
    checkOutput("t5_new_c2_ready", ready_o, 0);
    next_cycle();
    sample();
    checkOutput("t5_new_c3_ready",  ready_o,  1);
    checkOutput("t5_new_c3_result", result_o, 32'hCAFEF00D);
    next_cycle();
    idle_cycle();

    $display("[TB] flush in LAUNCH");
    applyStimulus(1'b1, 2'd0, 32'h0, 32'h0, 4'd2);
    next_cycle();
    flush_i = 1'b1;
    en_i    = 1'b0;
    sample();
    checkOutput("tf_c1_valid", fab_if.fab_op_valid_o, 0);
    checkOutput("tf_c1_abort", fab_if.fab_abort_o,    1);
    next_cycle();
    flush_i = 1'b0;
    sample();
    checkOutput("tf_c2_busy",   busy_o,   0);
    checkOutput("tf_c2_result", result_o, 32'hCAFEF00D);
    next_cycle();

    $display("[TB] illegal op then back-to-back op");
    fab_if.fab_result_a_i = 32'h13572468;
    applyStimulus(1'b1, 2'd3, 32'h99999999, 32'h0, 4'd0);
    sample();
    checkOutput("t6_c0_valid", fab_if.fab_op_valid_o, 0);
    next_cycle();
    applyStimulus(1'b1, 2'd0, 32'h13572468, 32'h0, 4'd0);
    sample();
    checkOutput("t6_c1_ready",  ready_o,  1);
    checkOutput("t6_c1_err",    err_o,    1);
    checkOutput("t6_c1_result", result_o, 32'd0);
    checkOutput("t6_c1_valid",  fab_if.fab_op_valid_o, 0);
    next_cycle();
    sample();
    checkOutput("t6_c2_busy",  busy_o,  0);
    checkOutput("t6_c2_err",   err_o,   0);
    checkOutput("t6_c2_ready", ready_o, 0);
    checkOutput("t6_c2_valid", fab_if.fab_op_valid_o, 0);
    next_cycle();
    sample();
    checkOutput("t6_c3_valid",  fab_if.fab_op_valid_o, 1);
    checkOutput("t6_c3_optype", fab_if.fab_optype_o,   0);
    next_cycle();
    sample();
    checkOutput("t6_c4_ready",  ready_o,  1);
    checkOutput("t6_c4_result", result_o, 32'h13572468);
    checkOutput("t6_c4_err",    err_o,    0);
    next_cycle();
    idle_cycle();

    $display("[TB] async reset mid-op");
    applyStimulus(1'b1, 2'd1, 32'hABCD0123, 32'h0, 4'd5);
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #2;
    checkOutput("ar_busy",   busy_o,   0);
    checkOutput("ar_result", result_o, 32'd0);
    checkOutput("ar_opa",    fab_if.fab_operand_a_o, 32'd0);
    checkOutput("ar_abort",  fab_if.fab_abort_o,     0);
    checkOutput("ar_valid",  fab_if.fab_op_valid_o,  0);
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
    #1;
    checkOutput("ar_ready", ready_o, 1);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
